// File: rtl/rsp_s2_prep_pkg.sv
// Shared types and sizing helpers for the S2 prep ping-pong RAM writer.
// Lane type, writer FSM states, beat count and address width helpers.
package rsp_s2_prep_pkg;

  localparam int SAMPLE_WIDTH_DEF = 32;

  typedef logic signed [SAMPLE_WIDTH_DEF/2-1:0] lane_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_DROP
  } wr_state_e;

  function automatic int f_beats(input int dn, input int bl);
    return dn / bl;
  endfunction

  function automatic int f_aw(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/rsp_s2_prep_wr_peak.sv
// Frame peak tracker: registered max |lane| per beat, then a frame accumulator.
// Built only when RSP_S2_PREP_WR_PP_PEAK_EN is defined.
module rsp_s2_prep_wr_peak
  import rsp_s2_prep_pkg::*;
#(
  parameter int LW        = 16,
  parameter int BURST_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [LW-1:0] i_lanes [BURST_LEN],
  input  logic                 i_vld,
  input  logic                 i_first,
  input  logic                 i_last,
  output logic        [LW-1:0] o_peak
);

  logic [LW-1:0] w_bmax;
  logic [LW-1:0] w_run;
  logic [LW-1:0] r_bmax;
  logic [LW-1:0] r_acc;
  logic          r_vld;
  logic          r_first;
  logic          r_last;

  // Most negative lane saturates so the result fits the signed range.
  function automatic logic [LW-1:0] f_abs(input logic signed [LW-1:0] v);
    logic signed [LW-1:0] mn;
    mn = {1'b1, {(LW-1){1'b0}}};
    if (v == mn) return {1'b0, {(LW-1){1'b1}}};
    else if (v < 0) return LW'(-v);
    else return LW'(v);
  endfunction

  always_comb begin
    w_bmax = '0;
    for (int k = 0; k < BURST_LEN; k++) begin
      if (f_abs(i_lanes[k]) > w_bmax) w_bmax = f_abs(i_lanes[k]);
    end
  end

  always_comb begin
    w_run = r_bmax;
    if (!r_first && r_acc > r_bmax) w_run = r_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bmax  <= '0;
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_acc   <= '0;
      o_peak  <= '0;
    end else begin
      r_vld   <= i_vld;
      r_first <= i_first;
      r_last  <= i_last;
      if (i_vld) r_bmax <= w_bmax;
      if (r_vld) begin
        r_acc <= w_run;
        if (r_last) o_peak <= w_run;
      end
    end
  end

endmodule

// File: rtl/rsp_s2_prep_wr_pp.sv
// Packs diff lanes into RAM words and fills a ping-pong RAM frame by frame.
// Optional frame peak output under RSP_S2_PREP_WR_PP_PEAK_EN.
module rsp_s2_prep_wr_pp
  import rsp_s2_prep_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 32,
  parameter int BURST_LEN    = 8,
  parameter int DATA_NUM     = 1024,
  parameter int RAM_WIDTH    = 128,
  localparam int LW    = SAMPLE_WIDTH / 2,
  localparam int BEATS = f_beats(DATA_NUM, BURST_LEN),
  localparam int AW    = f_aw(BEATS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [LW-1:0] i_y0_data [BURST_LEN],
  input  logic                 i_y0_valid,
  output logic                 o_ram_wr_en,
  output logic [AW:0]          o_ram_wr_addr,
  output logic [RAM_WIDTH-1:0] o_ram_wr_data,
  output logic [1:0]           o_bank_rdy,
  input  logic [1:0]           i_bank_done,
  output logic                 o_frame_done,
  output logic                 o_frame_bank,
  output logic [LW-1:0]        o_frame_peak,
  output logic                 o_ovf
);

  wr_state_e r_state;
  wr_state_e w_state_nx;

  logic                 r_bank;
  logic [AW-1:0]        r_cnt;
  logic                 r_commit;
  logic                 r_commit_bank;
  logic                 w_last;
  logic                 w_wr;
  logic                 w_drop;
  logic [1:0]           w_set;
  logic [1:0]           w_rdy_nx;
  logic [RAM_WIDTH-1:0] w_pack;

  assign w_last = (r_cnt == AW'(BEATS - 1));

  always_comb begin
    w_pack = '0;
    for (int k = 0; k < BURST_LEN; k++) begin
      w_pack[k*LW +: LW] = i_y0_data[k];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_wr       = 1'b0;
    w_drop     = 1'b0;
    if (i_y0_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (!o_bank_rdy[r_bank]) begin
            w_wr       = 1'b1;
            w_state_nx = w_last ? S_IDLE : S_WR;
          end else begin
            w_drop     = 1'b1;
            w_state_nx = w_last ? S_IDLE : S_DROP;
          end
        end
        S_WR: begin
          w_wr = 1'b1;
          if (w_last) w_state_nx = S_IDLE;
        end
        S_DROP: begin
          if (w_last) w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // A commit set wins over a same-cycle release of that bank.
  assign w_set    = {r_commit & r_commit_bank, r_commit & ~r_commit_bank};
  assign w_rdy_nx = (o_bank_rdy & ~i_bank_done) | w_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_bank        <= 1'b0;
      r_cnt         <= '0;
      r_commit      <= 1'b0;
      r_commit_bank <= 1'b0;
      o_ram_wr_en   <= 1'b0;
      o_ram_wr_addr <= '0;
      o_ram_wr_data <= '0;
      o_bank_rdy    <= '0;
      o_frame_done  <= 1'b0;
      o_frame_bank  <= 1'b0;
      o_ovf         <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      o_ram_wr_en <= w_wr;
      r_commit    <= w_wr & w_last;
      o_frame_done <= r_commit;
      o_bank_rdy  <= w_rdy_nx;
      if (i_y0_valid) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_wr) begin
        o_ram_wr_addr <= {r_bank, r_cnt};
        o_ram_wr_data <= w_pack;
      end
      if (w_wr && w_last) begin
        r_bank        <= ~r_bank;
        r_commit_bank <= r_bank;
      end
      if (r_commit) o_frame_bank <= r_commit_bank;
      if (w_drop) o_ovf <= 1'b1;
    end
  end

`ifdef RSP_S2_PREP_WR_PP_PEAK_EN
  logic w_first;
  assign w_first = (r_state == S_IDLE);

  rsp_s2_prep_wr_peak #(
    .LW        (LW),
    .BURST_LEN (BURST_LEN)
  ) u_peak (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_lanes (i_y0_data),
    .i_vld   (w_wr),
    .i_first (w_first),
    .i_last  (w_last),
    .o_peak  (o_frame_peak)
  );
`else
  assign o_frame_peak = '0;
`endif

endmodule
